// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check; drives pull-low enables only.
// Latency: clock inhibit starts the cycle after accept; data enable updates the cycle after a filtered falling edge.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is dropped, not queued.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int RQ_TIMEOUT_CYCLES    = 750000,
    parameter int FRAME_TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN           = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] err_code
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAITIDLE, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          flt_q, flt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [31:0]   timer_q, timer_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          fall, fin;
    logic [1:0]    fin_err;

    // The filtered clock only follows the synchronized pad after FILTER_LEN agreeing samples.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) flt_d = clk_s2_q;
            else                                  flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    assign fall = flt_q & ~flt_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        fin       = 1'b0;
        fin_err   = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d  = S_INHIBIT;
                    shift_d  = {~^tx_data, tx_data};
                    err_d    = 2'd0;
                    timer_d  = '0;
                    clk_oe_d = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (timer_q == 32'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_REQ;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_REQ: begin
                if (fall) begin
                    state_d = S_SEND;
                    bit_d   = 4'd0;
                    timer_d = '0;
                end else if (timer_q == 32'(RQ_TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    fin_err = 2'd1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_SEND, S_ACK, S_WAITIDLE: begin
                if (timer_q == 32'(FRAME_TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    fin_err = 2'd2;
                end else begin
                    timer_d = timer_q + 32'd1;
                    case (state_q)
                        S_SEND: begin
                            // Ones shift in behind parity, so the tenth fall releases data as the stop bit.
                            if (fall) begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b1, shift_q[8:1]};
                                bit_d     = bit_q + 4'd1;
                                if (bit_q == 4'd9) state_d = S_ACK;
                            end
                        end
                        S_ACK: begin
                            if (fall) begin
                                if (!dat_s2_q) begin
                                    state_d = S_WAITIDLE;
                                end else begin
                                    fin     = 1'b1;
                                    fin_err = 2'd3;
                                end
                            end
                        end
                        default: begin
                            if (flt_q && dat_s2_q) fin = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            state_d   = (fin_err == 2'd0) ? S_DONE : S_ERR;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = fin_err;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_data_i;
            dat_s2_q  <= dat_s1_q;
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign err_code    = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that clocks frames and ACKs.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int RQ  = 500;
    localparam int FR  = 1500;
    localparam int FL  = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

    wire clk_line   = ~(dev_clk_low | ps2_clk_oe);
    wire data_line  = ~(dev_data_low | ps2_data_oe);
    wire ps2_clk_i  = clk_line & ~glitch;
    wire ps2_data_i = data_line;

    int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, done_time = 0;
    logic [1:0] done_err = 2'd0;
    int h = 30;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RQ_TIMEOUT_CYCLES(RQ),
                  .FRAME_TIMEOUT_CYCLES(FR), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_err  = err_code;
            done_time = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required earlier end", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else n_pass++;
    endtask

    // Expected bit seen by the device on rising clock k: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] d);
        int w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        chk("ready_before_send", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("clk_oe_after_accept", 32'(ps2_clk_oe), 1);
    endtask

    task automatic dev_frame(input int nclk, input bit do_ack, input int abort_at,
                             output logic [10:0] bits, output bit ok);
        int w = 0;
        ok   = 1'b1;
        bits = '0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < INH + 100) begin
            @(negedge clk); w++;
        end
        if (w >= INH + 100) begin ok = 1'b0; return; end
        repeat (20) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            dev_clk_low = 1'b1;
            if (k == abort_at) begin
                repeat (h/2) @(negedge clk);
                reset_n = 1'b0;
                #1;
                chk("reset_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                chk("ready_after_reset", 32'({tx_ready, busy}), 32'h2);
                chk("err_after_reset", 32'(err_code), 0);
                return;
            end
            repeat (h) @(negedge clk);
            bits[k] = data_line;
            dev_clk_low = 1'b0;
            repeat (h) @(negedge clk);
        end
        if (nclk == 11) begin
            if (do_ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (h) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (h/2) @(negedge clk);
            dev_data_low = 1'b0;
            repeat (h) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int c0, input int bound, input string tag);
        int w = 0;
        while (done_cnt == c0 && w < bound) begin @(negedge clk); w++; end
        chk({tag, "_done_pulse"}, done_cnt - c0, 1);
    endtask

    task automatic run_txn(input logic [7:0] d, input int nclk, input bit ack, input logic [1:0] exp_err);
        logic [10:0] bits, mask;
        bit ok;
        int c0;
        c0 = done_cnt;
        send_req(d);
        dev_frame(nclk, ack, -1, bits, ok);
        chk("request_to_send", 32'(ok), 1);
        mask = 11'((1 << nclk) - 1);
        chk($sformatf("bits_%02h", d), 32'(bits & mask), 32'(frame_bits(d) & mask));
        wait_done(c0, 4000, $sformatf("txn_%02h", d));
        chk($sformatf("err_%02h", d), 32'(done_err), 32'(exp_err));
        @(negedge clk);
        chk($sformatf("released_%02h", d), 32'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        int         nclk;
        bit         ack;
        logic [1:0] exp_err;
    } vec_t;

    initial begin
        vec_t tbl [5];
        logic [10:0] bits;
        bit ok;
        int cnt, t_req, c0;
        logic [7:0] rd;
        bit rack;

        tbl[0] = '{8'hED, 11, 1'b1, 2'd0};
        tbl[1] = '{8'h01, 11, 1'b1, 2'd0};
        tbl[2] = '{8'hFF, 11, 1'b1, 2'd0};
        tbl[3] = '{8'hA5, 11, 1'b0, 2'd3};
        tbl[4] = '{8'h3C, 5,  1'b1, 2'd2};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({tx_ready, busy, tx_done, ps2_clk_oe, ps2_data_oe}), 32'h10);
        chk("reset_err", 32'(err_code), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'({tx_ready, busy}), 32'h2);

        for (int i = 0; i < 5; i++) run_txn(tbl[i].d, tbl[i].nclk, tbl[i].ack, tbl[i].exp_err);

        // Silent device: exact inhibit length, glitch immunity, dropped tx_valid, request timeout.
        c0 = done_cnt;
        @(negedge clk);
        tx_data  = 8'hAB;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("silent_clk_oe_n1", 32'({ps2_clk_oe, tx_ready, busy}), 32'h5);
        cnt = 0;
        while (ps2_clk_oe === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        chk("inhibit_len", cnt, INH);
        chk("req_data_oe", 32'(ps2_data_oe), 1);
        t_req = cyc;
        repeat (10) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_still_req", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'h3);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(c0, RQ + 100, "silent");
        chk("rq_timeout_time", done_time - t_req, RQ);
        chk("rq_timeout_err", 32'(done_err), 1);
        repeat (60) @(negedge clk);
        chk("no_second_frame", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready}), 32'h1);
        chk("err_held", 32'(err_code), 1);

        // Reset while D3 is on the line, then a clean frame.
        c0 = done_cnt;
        send_req(8'h5A);
        dev_frame(11, 1'b1, 4, bits, ok);
        chk("abort_rts", 32'(ok), 1);
        chk("abort_bits", 32'(bits & 11'h00F), 32'(frame_bits(8'h5A) & 11'h00F));
        chk("abort_no_done", done_cnt - c0, 0);
        repeat (5) @(negedge clk);
        run_txn(8'hF4, 11, 1'b1, 2'd0);

        for (int i = 0; i < 6; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            h    = int'($urandom_range(20, 40));
            run_txn(rd, 11, rack, rack ? 2'd0 : 2'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
